// File: rtl/game_event_scheduler_if.sv
// rtl/game_event_scheduler_if.sv - event offer/acknowledge handshake between scheduler and CPU register decode
interface game_event_scheduler_if;
  logic        event_valid;
  logic [31:0] event_code;
  logic        event_ack;

  modport master (
    output event_valid,
    output event_code,
    input  event_ack
  );

  modport slave (
    input  event_valid,
    input  event_code,
    output event_ack
  );
endinterface

// File: rtl/game_event_scheduler.sv
// rtl/game_event_scheduler.sv - synchronises game inputs, offers events by fixed priority, keeps frame/score/drop counters
module game_event_scheduler #(
  parameter int unsigned FRAME_DIV = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          button_signal,
  input  logic                          screen_signal,
  input  logic                          collision_signal,
  input  logic                          pause_signal,
  game_event_scheduler_if.master        evt,
  output logic [31:0]                   frame_count,
  output logic                          score_tick,
  output logic [7:0]                    drop_count
);

  localparam int SRC_PAUSE = 1;
  localparam int SRC_SCR   = 3;
  localparam logic [7:0] DIV_TOP = 8'(FRAME_DIV);

  typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;

  state_t     state, state_next;
  logic [3:0] raw_in, sync1, sync2, prev, armed;
  logic [1:0] sync_fill;
  logic [3:0] rise, pending, pending_next, eligible, pick;
  logic [3:0] grant, grant_next, clear_mask;
  logic [3:0] grant_code;
  logic [7:0] divider;
  logic       paused, ack_offer, drop_any;

  // Bit order doubles as priority: lowest index wins, code = index + 1.
  assign raw_in = {screen_signal, button_signal, pause_signal, collision_signal};

  // An edge only counts once a real low sample has passed through the synchroniser,
  // so inputs already high at reset release stay silent until they cycle low-high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      prev      <= '0;
      armed     <= '0;
      sync_fill <= '0;
    end else begin
      sync1     <= raw_in;
      sync2     <= sync1;
      prev      <= sync2;
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed | ({4{sync_fill[1]}} & ~sync2);
    end
  end

  assign rise   = sync2 & ~prev & armed;
  assign paused = sync2[SRC_PAUSE];

  assign eligible  = pending & {~paused, ~paused, 2'b11};
  assign pick      = eligible & (~eligible + 4'd1);
  assign ack_offer = (state == OFFER) && evt.event_ack;
  assign clear_mask = ack_offer ? grant : 4'b0000;

  assign pending_next = (pending & ~clear_mask) | rise;
  assign drop_any     = |(rise & pending & ~clear_mask);

  always_comb begin
    state_next = state;
    grant_next = grant;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_next = OFFER;
          grant_next = pick;
        end
      end
      OFFER: begin
        if (evt.event_ack) begin
          state_next = GAP;
          grant_next = 4'b0000;
        end
      end
      GAP: state_next = IDLE;
      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grant   <= '0;
      pending <= '0;
    end else begin
      state   <= state_next;
      grant   <= grant_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    grant_code = 4'd0;
    case (grant)
      4'b0001: grant_code = 4'd1;
      4'b0010: grant_code = 4'd2;
      4'b0100: grant_code = 4'd3;
      4'b1000: grant_code = 4'd4;
      default: grant_code = 4'd0;
    endcase
  end

  assign evt.event_valid = (state == OFFER);
  assign evt.event_code  = {28'd0, grant_code};

  // Frame and score counting follow screen edges only and never wait on the handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
      divider     <= '0;
      score_tick  <= 1'b0;
    end else begin
      score_tick <= 1'b0;
      if (rise[SRC_SCR] && !paused) begin
        frame_count <= frame_count + 32'd1;
        if (divider + 8'd1 == DIV_TOP) begin
          divider    <= '0;
          score_tick <= 1'b1;
        end else begin
          divider <= divider + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (drop_any && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_game_event_scheduler.sv
// tb/tb_game_event_scheduler.sv - directed and randomized checks of game_event_scheduler against a behavioural model
module tb_game_event_scheduler;
  localparam int FD = 6;
  localparam int M_IDLE = 0, M_OFFER = 1, M_GAP = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        button_signal = 1'b0, screen_signal = 1'b0;
  logic        collision_signal = 1'b0, pause_signal = 1'b0;
  logic [31:0] frame_count;
  logic        score_tick;
  logic [7:0]  drop_count;

  game_event_scheduler_if evt_if();

  game_event_scheduler #(.FRAME_DIV(FD)) dut (
    .clock           (clock),
    .reset           (reset),
    .button_signal   (button_signal),
    .screen_signal   (screen_signal),
    .collision_signal(collision_signal),
    .pause_signal    (pause_signal),
    .evt             (evt_if),
    .frame_count     (frame_count),
    .score_tick      (score_tick),
    .drop_count      (drop_count)
  );

  always #5 clock = ~clock;

  int checks, errors, tick_seen;

  // Reference model: per-source sample history since reset, event rules applied directly.
  bit        q [4][$];
  int        edge_n;
  int        m_state, m_code, m_div, m_drop;
  bit        m_pend [4];
  bit [31:0] m_frame;
  bit        m_tick;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      m_pend[i] = 1'b0;
    end
    edge_n = 0; m_state = M_IDLE; m_code = 0; m_div = 0; m_drop = 0;
    m_frame = '0; m_tick = 1'b0;
  endtask

  task automatic model_step();
    bit x [4];
    bit rise [4];
    bit paused, dropped;
    int clr, nst, ncode, sz;
    x[0] = collision_signal; x[1] = pause_signal; x[2] = button_signal; x[3] = screen_signal;
    edge_n++;
    for (int i = 0; i < 4; i++) begin
      q[i].push_back(x[i]);
      if (q[i].size() > 4) void'(q[i].pop_front());
    end
    sz = q[0].size();
    // A sample taken at edge e becomes visible two edges later; a rise needs a 0 then a 1.
    for (int i = 0; i < 4; i++)
      rise[i] = (edge_n >= 4) && q[i][sz-3] && !q[i][sz-4];
    paused = (edge_n >= 3) && q[1][sz-3];
    clr = (m_state == M_OFFER && evt_if.event_ack) ? m_code - 1 : -1;
    nst = m_state; ncode = m_code;
    case (m_state)
      M_IDLE: begin
        for (int i = 3; i >= 0; i--)
          if (m_pend[i] && !(paused && i >= 2)) begin
            nst = M_OFFER; ncode = i + 1;
          end
      end
      M_OFFER: if (evt_if.event_ack) begin nst = M_GAP; ncode = 0; end
      default: nst = M_IDLE;
    endcase
    dropped = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rise[i] && m_pend[i] && i != clr) dropped = 1'b1;
      m_pend[i] = (m_pend[i] && i != clr) || rise[i];
    end
    if (dropped && m_drop < 255) m_drop++;
    m_tick = 1'b0;
    if (rise[3] && !paused) begin
      m_frame++;
      m_div++;
      if (m_div == FD) begin m_div = 0; m_tick = 1'b1; end
    end
    m_state = nst; m_code = ncode;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    if (score_tick) tick_seen++;
    check("valid", evt_if.event_valid, m_state == M_OFFER);
    check("code", evt_if.event_code, m_code);
    check("frame", frame_count, m_frame);
    check("tick", score_tick, m_tick);
    check("drop", drop_count, m_drop);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    #20;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles, input string tag);
    int n = 0;
    while (!evt_if.event_valid && n < max_cycles) begin
      cycle();
      n++;
    end
    check(tag, evt_if.event_valid, 1'b1);
  endtask

  task automatic ack_once();
    evt_if.event_ack = 1'b1;
    cycle();
    evt_if.event_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; tick_seen = 0;
    evt_if.event_ack = 1'b0;
    model_reset();
    #23;
    check("rst_valid", evt_if.event_valid, 1'b0);
    check("rst_code", evt_if.event_code, 32'd0);
    check("rst_frame", frame_count, 32'd0);
    check("rst_tick", score_tick, 1'b0);
    check("rst_drop", drop_count, 8'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (4) cycle();

    // Button pulse: offered on edge k+3, then a one-cycle gap after ack.
    button_signal = 1'b1; cycle();
    button_signal = 1'b0; cycle(); cycle();
    check("btn_k2_valid", evt_if.event_valid, 1'b0);
    cycle();
    check("btn_k3_valid", evt_if.event_valid, 1'b1);
    check("btn_k3_code", evt_if.event_code, 32'd3);
    ack_once();
    check("gap_valid", evt_if.event_valid, 1'b0);
    check("gap_code", evt_if.event_code, 32'd0);
    cycle();
    check("idle_after_gap", evt_if.event_valid, 1'b0);

    // Collision and button together: collision first.
    collision_signal = 1'b1; button_signal = 1'b1; cycle();
    collision_signal = 1'b0; button_signal = 1'b0;
    wait_valid(6, "coll_offer");
    check("coll_first", evt_if.event_code, 32'd1);
    ack_once();
    check("coll_gap", evt_if.event_valid, 1'b0);
    wait_valid(4, "btn_after_coll");
    check("btn_second", evt_if.event_code, 32'd3);
    ack_once();
    cycle();

    // Pause holds the button back until released.
    pause_signal = 1'b1;
    wait_valid(6, "pause_offer");
    check("pause_code", evt_if.event_code, 32'd2);
    button_signal = 1'b1; cycle();
    button_signal = 1'b0;
    ack_once();
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("btn_held_while_paused", evt_if.event_valid, 1'b0);
    end
    pause_signal = 1'b0;
    wait_valid(6, "btn_after_unpause");
    check("btn_after_unpause_code", evt_if.event_code, 32'd3);
    ack_once();
    cycle();

    // Twelve unpaused frames with FRAME_DIV=6.
    do_reset();
    repeat (3) cycle();
    tick_seen = 0;
    for (int i = 0; i < 12; i++) begin
      screen_signal = 1'b1; cycle();
      screen_signal = 1'b0; cycle();
    end
    repeat (4) cycle();
    check("frame_12", frame_count, 32'd12);
    check("ticks_2", tick_seen, 2);

    // 300 button edges with no ack saturate the drop counter.
    do_reset();
    repeat (3) cycle();
    for (int i = 0; i < 300; i++) begin
      button_signal = 1'b1; cycle();
      button_signal = 1'b0; cycle();
    end
    repeat (3) cycle();
    check("drop_sat", drop_count, 8'd255);
    check("drop_code", evt_if.event_code, 32'd3);
    check("drop_valid", evt_if.event_valid, 1'b1);

    // Asynchronous reset in the middle of an offer.
    do_reset();
    repeat (3) cycle();
    for (int i = 0; i < 3; i++) begin
      screen_signal = 1'b1; button_signal = 1'b1; cycle();
      screen_signal = 1'b0; button_signal = 1'b0; cycle();
    end
    wait_valid(6, "offer_before_reset");
    @(posedge clock);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("arst_valid", evt_if.event_valid, 1'b0);
    check("arst_code", evt_if.event_code, 32'd0);
    check("arst_frame", frame_count, 32'd0);
    check("arst_drop", drop_count, 8'd0);
    check("arst_tick", score_tick, 1'b0);
    collision_signal = 1'b1;
    #20;
    @(negedge clock);
    reset = 1'b1;
    repeat (10) cycle();
    check("no_offer_after_release", evt_if.event_valid, 1'b0);
    collision_signal = 1'b0; cycle();
    collision_signal = 1'b1; cycle();
    collision_signal = 1'b0;
    wait_valid(6, "coll_after_release");
    check("coll_after_release_code", evt_if.event_code, 32'd1);
    ack_once();

    // Randomized traffic against the model.
    button_signal = 1'b0; screen_signal = 1'b0; collision_signal = 1'b0; pause_signal = 1'b0;
    do_reset();
    repeat (3) cycle();
    for (int i = 0; i < 2000; i++) begin
      collision_signal = ($urandom_range(0, 9) == 0);
      button_signal    = ($urandom_range(0, 3) == 0);
      screen_signal    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 59) == 0) pause_signal = ~pause_signal;
      evt_if.event_ack = ($urandom_range(0, 2) == 0);
      cycle();
    end
    evt_if.event_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
